// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: controller states and
// the bit-counter width helper.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count WIDTH bit steps (0 .. WIDTH-1).
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/fs_cell.sv
// Combinational 1-bit full subtractor: d = a - b - bi, with borrow-out bo.
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor D = A - B - Bin, LSB first, one bit per
// cycle through a single fs_cell, with start/busy/done handshake and flags.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bo,
  output logic             V,
  output logic             Z
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sa_q, sb_q, r_q;
  logic             br_q;

  logic             d_bit, bo_bit;
  logic             accept, last_step;
  logic [WIDTH-1:0] r_next;

  fs_cell u_cell (
    .a  (sa_q[0]),
    .b  (sb_q[0]),
    .bi (br_q),
    .d  (d_bit),
    .bo (bo_bit)
  );

  // start is only honoured when no operation is in flight.
  assign accept    = start && (state_q != RUN);
  assign last_step = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));
  assign r_next    = {d_bit, r_q[WIDTH-1:1]};

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  always_comb begin
    // NOTE: default assigned first so every path drives state_d (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all flops sample pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      r_q     <= '0;
      br_q    <= 1'b0;
      D       <= '0;
      Bo      <= 1'b0;
      V       <= 1'b0;
      Z       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sa_q  <= A;
        sb_q  <= B;
        br_q  <= Bin;
        cnt_q <= '0;
      end else if (state_q == RUN) begin
        sa_q  <= sa_q >> 1;
        sb_q  <= sb_q >> 1;
        br_q  <= bo_bit;
        r_q   <= r_next;
        cnt_q <= cnt_q + CW'(1);
        // Borrow into the MSB xor borrow out of it flags signed overflow.
        if (last_step) begin
          D  <= r_next;
          Bo <= bo_bit;
          V  <= br_q ^ bo_bit;
          Z  <= (r_next == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: 8-bit directed, robustness and random runs plus an
// exhaustive 2-bit sweep, against an arithmetic reference model.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       start8, bin8;
  logic [7:0] a8, b8, d8;
  logic       busy8, done8, bo8, v8, z8;

  logic       start2, bin2;
  logic [1:0] a2, b2, d2;
  logic       busy2, done2, bo2, v2, z2;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .Bin(bin8),
    .busy(busy8), .done(done8), .D(d8), .Bo(bo8), .V(v8), .Z(z8)
  );

  serial_subtractor #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .A(a2), .B(b2), .Bin(bin2),
    .busy(busy2), .done(done2), .D(d2), .Bo(bo2), .V(v2), .Z(z2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic model(input int w, input int a, input int b, input int bin,
                       output int d, output int bo, output int v, output int z);
    int m, half, diff, sa, sb, sd;
    m    = 1 << w;
    half = m / 2;
    diff = a - b - bin;
    d    = (diff + m) % m;
    bo   = (diff < 0) ? 1 : 0;
    sa   = (a >= half) ? a - m : a;
    sb   = (b >= half) ? b - m : b;
    sd   = sa - sb - bin;
    v    = (sd < -half || sd > half - 1) ? 1 : 0;
    z    = (d == 0) ? 1 : 0;
  endtask

  // Drive operands away from the edge; return #1 after the accepting edge.
  task automatic go8(input int a, input int b, input int bin);
    a8 = 8'(a); b8 = 8'(b); bin8 = 1'(bin); start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  task automatic wait8(input string tag, input int a, input int b, input int bin,
                       input int elapsed);
    int lat, busyc, ed, eb, ev, ez;
    lat   = elapsed;
    busyc = elapsed + (busy8 ? 1 : 0);
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy8) busyc++;
    end
    model(8, a, b, bin, ed, eb, ev, ez);
    check({tag, ".latency"}, 32'(lat), 32'd8);
    check({tag, ".busy_cycles"}, 32'(busyc), 32'd8);
    check({tag, ".D"}, 32'(d8), 32'(ed));
    check({tag, ".Bo"}, 32'(bo8), 32'(eb));
    check({tag, ".V"}, 32'(v8), 32'(ev));
    check({tag, ".Z"}, 32'(z8), 32'(ez));
  endtask

  task automatic go2(input int a, input int b, input int bin);
    a2 = 2'(a); b2 = 2'(b); bin2 = 1'(bin); start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
  endtask

  task automatic wait2(input string tag, input int a, input int b, input int bin);
    int lat, ed, eb, ev, ez;
    lat = 0;
    while (!done2 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    model(2, a, b, bin, ed, eb, ev, ez);
    check({tag, ".latency"}, 32'(lat), 32'd2);
    check({tag, ".flags"}, {26'd0, z2, v2, bo2, 1'b0, d2},
          {26'd0, 1'(ez), 1'(ev), 1'(eb), 1'b0, 2'(ed)});
  endtask

  initial begin
    int dones;
    int ra, rb, rbin;
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; bin2 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("reset.dut8", {26'd0, busy8, done8, bo8, v8, z8, |d8}, 32'd0);
    check("reset.dut2", {26'd0, busy2, done2, bo2, v2, z2, |d2}, 32'd0);

    go8(8'h05, 8'h03, 0);
    check("t1.busy_after_accept", 32'(busy8), 32'd1);
    wait8("t1", 8'h05, 8'h03, 0, 0);
    @(posedge clk); #1;
    check("t1.done_one_cycle", {30'd0, done8, busy8}, 32'd0);

    go8(8'h03, 8'h05, 0); wait8("t2", 8'h03, 8'h05, 0, 0);
    @(posedge clk); #1;
    go8(8'h80, 8'h01, 0); wait8("t3", 8'h80, 8'h01, 0, 0);
    @(posedge clk); #1;
    go8(8'h10, 8'h0F, 1); wait8("t4", 8'h10, 8'h0F, 1, 0);
    // Back-to-back: start during the DONE cycle.
    go8(8'h00, 8'h00, 1);
    check("t5.b2b_busy", {30'd0, busy8, done8}, 32'd2);
    wait8("t5", 8'h00, 8'h00, 1, 0);
    @(posedge clk); #1;

    // Reset at edge 4 of a run.
    go8(8'h5A, 8'h33, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid.state", {30'd0, busy8, done8}, 32'd0);
    check("rst_mid.D", 32'(d8), 32'd0);
    check("rst_mid.flags", {29'd0, bo8, v8, z8}, 32'd0);
    dones = 0;
    repeat (24) begin
      @(posedge clk); #1;
      if (done8) dones++;
    end
    check("rst_mid.no_done", 32'(dones), 32'd0);

    // start with new operands mid-RUN is ignored.
    go8(8'hC3, 8'h4E, 1);
    @(posedge clk); #1;
    a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    wait8("midstart", 8'hC3, 8'h4E, 1, 2);
    @(posedge clk); #1;

    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int bin = 0; bin < 2; bin++) begin
          go2(a, b, bin);
          wait2($sformatf("w2_%0d_%0d_%0d", a, b, bin), a, b, bin);
          @(posedge clk); #1;
        end

    for (int i = 0; i < 40; i++) begin
      ra   = int'($urandom_range(0, 255));
      rb   = int'($urandom_range(0, 255));
      rbin = int'($urandom_range(0, 1));
      go8(ra, rb, rbin);
      wait8($sformatf("rnd%0d", i), ra, rb, rbin, 0);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Parametrised bit-serial N-bit subtractor computing D = A − B − Bin, LSB first, through a single full-subtractor cell and a registered borrow. Successor to the one-bit full subtractor: the width is generic, and it adds a start/busy/done handshake, a held result, a borrow-out, signed overflow and zero flags. It is used wherever a wide subtract is needed at low area and WIDTH-cycle latency is acceptable.

## Interface
- WIDTH, 8, operand and result width in bits; legal range WIDTH ≥ 2.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- A  in  WIDTH  minuend; sampled on the accepting edge.
- B  in  WIDTH  subtrahend; sampled on the accepting edge.
- Bin  in  1  borrow-in; sampled on the accepting edge.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result valid.
- D  out  WIDTH  difference, registered, held until the next completion.
- Bo  out  1  unsigned borrow-out of the MSB.
- V  out  1  signed (two's-complement) overflow.
- Z  out  1  D == 0.

## Operation
- Control is an FSM with three states: IDLE, RUN, DONE.
- **Transitions**
  - IDLE→RUN on start.
  - RUN→DONE after WIDTH bit steps.
  - DONE→RUN if start, otherwise DONE→IDLE.
- **Accept (edge 0):**
  - A and B load into shift registers sa and sb.
  - The borrow register br loads Bin.
  - The bit counter clears to 0.
- **Each RUN edge:**
  - d = sa[0]^sb[0]^br.
  - br ← (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&br).
  - sa and sb shift right.
  - d shifts into the MSB of the internal result register r.
  - The counter increments.
- **Final step (counter == WIDTH−1):**
  - Output registers update: D ← final r, Bo ← br_next, V ← br ^ br_next (borrow into MSB xor borrow out of MSB), Z ← (final r == 0).
  - The state moves to DONE.
- D, Bo, V and Z change only on the final step edge or on reset. Inputs A, B and Bin are ignored outside the accepting edge.
- start while busy is ignored, with no effect on the operation in flight.
- **Arithmetic:** the result is modulo 2^WIDTH. Bo=1 iff A < B+Bin (unsigned). V=1 iff the signed A−B−Bin falls outside [−2^(WIDTH−1), 2^(WIDTH−1)−1].

## Timing
- With start sampled at edge 0:
  - Bit k is processed at edge k+1.
  - The outputs update and the state enters DONE at edge WIDTH.
  - done is high for exactly the cycle between edge WIDTH and edge WIDTH+1.
- busy is high from after edge 0 until edge WIDTH; it is low in IDLE and DONE.
- Back-to-back operation: start high during the DONE cycle is accepted at edge WIDTH+1. Throughput is therefore one result per WIDTH+1 cycles.
- **Reset:** when rst is high at an edge, all of the following hold after that edge, regardless of state, including mid-RUN:
  - state is IDLE;
  - busy=0, done=0;
  - D=0, Bo=0, V=0, Z=0;
  - br=0, counter=0;
  - any partial result is discarded.
- rst has priority over start on the same edge.

## Structure
- Shared package sub_pkg holds:
  - the state typedef (IDLE, RUN, DONE);
  - a localparam-style function for the counter width, $clog2(WIDTH).
- Sub-module fs_cell is the combinational 1-bit full subtractor: inputs a, b, bi; outputs d, bo. The top instantiates it once in the serial datapath.
- The top holds the FSM, the counter, the sa/sb/r shift registers, the br flop and the output registers.

## Test plan
- WIDTH=8, A=0x05, B=0x03, Bin=0.
  - D=0x02, Bo=0, V=0, Z=0.
  - done is high exactly 8 edges after the start edge; busy is high for 8 cycles.
- WIDTH=8, A=0x03, B=0x05, Bin=0 → D=0xFE, Bo=1, V=0, Z=0.
- WIDTH=8, A=0x80, B=0x01, Bin=0 → D=0x7F, Bo=0, V=1.
- WIDTH=8, A=0x10, B=0x0F, Bin=1 → D=0x00, Bo=0, Z=1. Immediately follow with start in the DONE cycle using A=0x00, B=0x00, Bin=1 → D=0xFF, Bo=1, V=0.
- WIDTH=2 exhaustive: all 32 (A, B, Bin) combinations. Compare against a reference {Bo,D} = A−B−Bin, with V checked against the signed range.
- Robustness, WIDTH=8:
  - Assert rst at edge 4 of a run → next cycle state IDLE, busy=0, done=0, D=0, Bo=0, V=0, Z=0, with no done pulse afterwards.
  - Pulse start with new operands mid-RUN → ignored; the original result completes unchanged.
